// File: rtl/mem_burst_if.sv
// Command / burst-data bus between a cache controller (master) and the
// line memory model (slave).
//   cmd_valid/cmd_ready  request handshake
//   cmd_write, cmd_addr  operation and byte address
//   wdata, wdata_valid   write beats, master to slave
//   rdata, rdata_valid   read beats, slave to master
//   done                 one-cycle completion pulse
interface mem_burst_if #(
  parameter int ADDR_WIDTH = 19,
  parameter int BUS_BYTES  = 2
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic                   cmd_write;
  logic [ADDR_WIDTH-1:0]  cmd_addr;
  logic [BUS_BYTES*8-1:0] wdata;
  logic                   wdata_valid;
  logic [BUS_BYTES*8-1:0] rdata;
  logic                   rdata_valid;
  logic                   done;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, wdata, wdata_valid,
    input  cmd_ready, rdata, rdata_valid, done
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, wdata, wdata_valid,
    output cmd_ready, rdata, rdata_valid, done
  );
endinterface

// File: rtl/mem_burst_model.sv
// Line-granular main-memory model with configurable latency and multi-beat
// bursts. One line request is serviced at a time.
//   clk    posedge clock
//   rst_n  asynchronous active-low reset (storage is not cleared)
//   bus    mem_burst_if slave: command handshake, write beats, read beats, done
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | ready for a command (held off for the done cycle)
// WCOLLECT | gathering write beats into the line buffer
// WWAIT    | latency countdown; commit at lat_cnt==1, done at lat_cnt==0
// RWAIT    | latency countdown before the read burst
// RBURST   | one read beat per cycle, done on the last beat
module mem_burst_model #(
  parameter int ADDR_WIDTH = 19,
  parameter int LINE_BYTES = 16,
  parameter int BUS_BYTES  = 2,
  parameter int LATENCY    = 100
) (
  input logic        clk,
  input logic        rst_n,
  mem_burst_if.slave bus
);
  localparam int BEATS   = LINE_BYTES / BUS_BYTES;
  localparam int BUS_W   = BUS_BYTES * 8;
  localparam int OFF_W   = $clog2(LINE_BYTES);
  localparam int LINE_AW = ADDR_WIDTH - OFF_W;
  localparam int LAT_W   = $clog2(LATENCY + 1);
  localparam int BC_W    = $clog2(BEATS) + 1;
  localparam int IDX_W   = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [LAT_W-1:0] LAT_INIT  = LAT_W'(LATENCY);
  localparam logic [LAT_W-1:0] LAT_ONE   = LAT_W'(1);
  localparam logic [BC_W-1:0]  LAST_BEAT = BC_W'(BEATS - 1);

  typedef enum logic [2:0] {IDLE, WCOLLECT, WWAIT, RWAIT, RBURST} state_t;
  typedef logic [BEATS-1:0][BUS_W-1:0] line_t;

  state_t             state, state_nxt;
  logic [LAT_W-1:0]   lat_cnt;
  logic [BC_W-1:0]    beat_cnt;
  logic [IDX_W-1:0]   beat_idx;
  logic [LINE_AW-1:0] line_addr;
  line_t              wbuf;
  line_t              mem [2**LINE_AW];

  logic               accept, beat_in, commit;
  logic               done_d, rvalid_d;
  logic [BUS_W-1:0]   rdata_d;
  logic               done_q, rvalid_q;
  logic [BUS_W-1:0]   rdata_q;
  logic               addr_unused;

  // Ready drops during the done cycle so a held request is taken only after it.
  assign bus.cmd_ready = (state == IDLE) && !done_q;
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign beat_in       = (state == WCOLLECT) && bus.wdata_valid;
  assign commit        = (state == WWAIT) && (lat_cnt == LAT_ONE);
  assign beat_idx      = beat_cnt[IDX_W-1:0];
  assign addr_unused   = ^bus.cmd_addr[OFF_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = bus.cmd_write ? WCOLLECT : RWAIT;
      WCOLLECT: if (beat_in && beat_cnt == LAST_BEAT) state_nxt = WWAIT;
      WWAIT:    if (lat_cnt == '0) state_nxt = IDLE;
      RWAIT:    if (lat_cnt == LAT_ONE) state_nxt = RBURST;
      RBURST:   if (beat_cnt == LAST_BEAT) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    done_d   = 1'b0;
    rvalid_d = 1'b0;
    rdata_d  = '0;
    case (state)
      WWAIT:  done_d = (lat_cnt == '0);
      RBURST: begin
        rvalid_d = 1'b1;
        rdata_d  = mem[line_addr][beat_idx];
        done_d   = (beat_cnt == LAST_BEAT);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      done_q   <= done_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.done        = done_q;
  assign bus.rdata_valid = rvalid_q;
  assign bus.rdata       = rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt   <= '0;
      beat_cnt  <= '0;
      line_addr <= '0;
      wbuf      <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          line_addr <= bus.cmd_addr[ADDR_WIDTH-1:OFF_W];
          beat_cnt  <= '0;
          lat_cnt   <= LAT_INIT;
        end
        WCOLLECT: if (beat_in) begin
          wbuf[beat_idx] <= bus.wdata;
          beat_cnt       <= beat_cnt + 1'b1;
          if (beat_cnt == LAST_BEAT) lat_cnt <= LAT_INIT;
        end
        WWAIT: if (lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
        RWAIT: begin
          lat_cnt <= lat_cnt - 1'b1;
          if (lat_cnt == LAT_ONE) beat_cnt <= '0;
        end
        RBURST: beat_cnt <= beat_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Whole-line commit in a single cycle; storage has no reset.
  always_ff @(posedge clk) begin
    if (commit) mem[line_addr] <= wbuf;
  end
endmodule

// File: tb/tb_mem_burst_model.sv
module tb_mem_burst_model;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int sel = 0;
  int beats, bb, lat, lb;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0, wdata_valid = 1'b0;
  logic [18:0] cmd_addr = '0;
  logic [31:0] wdata = '0;

  mem_burst_if #(.ADDR_WIDTH(19), .BUS_BYTES(2)) bus0 ();
  mem_burst_if #(.ADDR_WIDTH(19), .BUS_BYTES(4)) bus1 ();

  assign bus0.cmd_valid   = cmd_valid && (sel == 0);
  assign bus0.cmd_write   = cmd_write;
  assign bus0.cmd_addr    = cmd_addr;
  assign bus0.wdata       = wdata[15:0];
  assign bus0.wdata_valid = wdata_valid && (sel == 0);
  assign bus1.cmd_valid   = cmd_valid && (sel == 1);
  assign bus1.cmd_write   = cmd_write;
  assign bus1.cmd_addr    = cmd_addr;
  assign bus1.wdata       = wdata;
  assign bus1.wdata_valid = wdata_valid && (sel == 1);

  mem_burst_model dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  mem_burst_model #(.LINE_BYTES(32), .BUS_BYTES(4), .LATENCY(1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  logic        ready, rvalid, done_o;
  logic [31:0] rdata_o;
  always_comb begin
    ready   = (sel == 0) ? bus0.cmd_ready   : bus1.cmd_ready;
    rvalid  = (sel == 0) ? bus0.rdata_valid : bus1.rdata_valid;
    done_o  = (sel == 0) ? bus0.done        : bus1.done;
    rdata_o = (sel == 0) ? {16'h0, bus0.rdata} : bus1.rdata;
  end

  // Reference storage: one byte per entry, keyed by DUT and byte address.
  logic [7:0] ref_mem [int];
  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int key(input logic [18:0] addr, input int i);
    return sel * (1 << 20) + (int'(addr) & ~(lb - 1)) + i;
  endfunction

  task automatic use_dut(input int s);
    sel = s;
    if (s == 0) begin lb = 16; bb = 2; lat = 100; end
    else        begin lb = 32; bb = 4; lat = 1;   end
    beats = lb / bb;
  endtask

  task automatic accept_cmd(input logic wr, input logic [18:0] addr, output int acc);
    bit got = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
    for (int i = 0; i < 400 && !got; i++) begin
      if (ready) got = 1;
      @(negedge clk);
    end
    acc = cyc;
    chk("accept_seen", 32'(got), 32'd1);
  endtask

  // pat: 0 = byte index, 1 = random, 2 = all 0xAA. abort_after >= 0 resets
  // that many cycles into the latency wait instead of completing.
  task automatic write_line(input logic [18:0] addr, input int pat,
                            input int max_gap, input int abort_after);
    logic [7:0] line [32];
    int acc, last;
    bit bad = 0, got = 0;
    for (int i = 0; i < lb; i++)
      line[i] = (pat == 0) ? 8'(i) : (pat == 2) ? 8'hAA : 8'($urandom);
    wdata_valid = 1'b1; wdata = 32'hDEAD_BEEF;   // must be ignored at acceptance
    accept_cmd(1'b1, addr, acc);
    cmd_valid = 1'b0;
    for (int k = 0; k < beats; k++) begin
      int gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (gap) begin
        wdata_valid = 1'b0; wdata = 32'hBAD0_BAD0;
        if (ready) bad = 1;
        @(negedge clk);
      end
      wdata = '0;
      for (int b = 0; b < bb; b++) wdata[8*b +: 8] = line[k*bb + b];
      wdata_valid = 1'b1;
      if (ready) bad = 1;
      @(negedge clk);
      last = cyc;
    end
    wdata_valid = 1'b0; wdata = '0;
    if (abort_after >= 0) begin
      repeat (abort_after) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_rvalid", 32'(rvalid), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_rdata", rdata_o, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
    end else begin
      for (int i = 0; i < lat + 50 && !got; i++) begin
        if (done_o) got = 1;
        else begin
          if (ready) bad = 1;
          @(negedge clk);
        end
      end
      chk("wr_done_seen", 32'(got), 32'd1);
      chk("wr_done_latency", 32'(cyc - last), 32'(lat + 1));
      chk("wr_ready_busy", 32'(bad), 32'd0);
      for (int i = 0; i < lb; i++) ref_mem[key(addr, i)] = line[i];
      @(negedge clk);
      chk("wr_tail", {29'd0, rvalid, done_o, ready}, 32'd1);
    end
  endtask

  task automatic read_line(input logic [18:0] addr, input bit hold,
                           input logic [18:0] hold_addr, output int acc);
    bit bad = 0, got = 0;
    logic [31:0] exp;
    accept_cmd(1'b0, addr, acc);
    if (hold) cmd_addr = hold_addr;   // changes while busy must not matter
    else      cmd_valid = 1'b0;
    for (int i = 0; i < lat + 50 && !got; i++) begin
      if (rvalid) got = 1;
      else begin
        if (ready) bad = 1;
        @(negedge clk);
      end
    end
    chk("rd_first_seen", 32'(got), 32'd1);
    chk("rd_first_latency", 32'(cyc - acc), 32'(lat + 1));
    for (int k = 0; k < beats; k++) begin
      exp = '0;
      for (int b = 0; b < bb; b++) exp[8*b +: 8] = ref_mem[key(addr, k*bb + b)];
      chk("rd_beat", rdata_o, exp);
      if (!rvalid || (done_o != (k == beats - 1)) || ready) bad = 1;
      @(negedge clk);
    end
    chk("rd_ctrl", 32'(bad), 32'd0);
    chk("rd_tail", {29'd0, rvalid, done_o, ready}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int acc, t;
    logic [18:0] ra;
    use_dut(0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_rvalid", 32'(rvalid), 32'd0);
    chk("reset_done", 32'(done_o), 32'd0);
    chk("reset_rdata", rdata_o, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic line write then read, including the unaligned-address alias.
    write_line(19'h00100, 0, 0, -1);
    read_line(19'h00100, 1'b0, '0, acc);
    read_line(19'h0010F, 1'b0, '0, acc);

    // Write beats arriving with random gaps.
    write_line(19'h02340, 1, 3, -1);
    read_line(19'h02340, 1'b0, '0, acc);

    // A request held through a read burst is taken only after done.
    write_line(19'h01230, 1, 0, -1);
    read_line(19'h00100, 1'b1, 19'h01230, acc);
    t = cyc;
    read_line(19'h01230, 1'b0, '0, acc);
    chk("held_accept_cycle", 32'(acc), 32'(t + 1));

    for (int n = 0; n < 3; n++) begin
      ra = 19'($urandom);
      write_line(ra, 1, 2, -1);
      read_line(ra, 1'b0, '0, acc);
    end

    // Top line; reset during the latency wait discards the write.
    write_line(19'h7FFF0, 2, 0, -1);
    read_line(19'h7FFF0, 1'b0, '0, acc);
    write_line(19'h7FFF0, 1, 0, 10);
    read_line(19'h7FFF5, 1'b0, '0, acc);

    // Wide-bus, minimum-latency instance.
    use_dut(1);
    write_line(19'h00200, 1, 1, -1);
    read_line(19'h00200, 1'b0, '0, acc);
    write_line(19'h7FFE0, 1, 0, -1);
    read_line(19'h7FFFF, 1'b0, '0, acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_burst_model.md
Name: mem_burst_model

Overview:
- Parametrised line-granular main-memory model for the cache testbench.
- Successor to the fixed single-cycle line memory: explicit valid/ready command handshake, configurable access latency, and line transfer in multi-beat bursts over a narrower data bus.
- Separate directional read and write buses; no tri-state ports.
- Sits below the cache controller and services one line request at a time.

Parameters:
- ADDR_WIDTH, 19, byte-address width; storage is 2^ADDR_WIDTH bytes.
- LINE_BYTES, 16, cache-line size in bytes; power of two.
- BUS_BYTES, 2, bytes per data beat; power of two and at most LINE_BYTES.
- LATENCY, 100, cycles from command acceptance (read) or last write beat (write) to data/commit; must be at least 1.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  request present.
- cmd_ready  out  1  model can accept a request.
- cmd_write  in  1  0 = read line, 1 = write line.
- cmd_addr  in  ADDR_WIDTH  byte address; low log2(LINE_BYTES) bits ignored (line-aligned).
- wdata  in  BUS_BYTES*8  write beat; byte 0 in bits [7:0].
- wdata_valid  in  1  wdata holds the next write beat.
- rdata  out  BUS_BYTES*8  read beat; same byte order as wdata.
- rdata_valid  out  1  rdata holds a valid beat.
- done  out  1  one-cycle pulse when the request completes.

Behaviour:
- BEATS = LINE_BYTES/BUS_BYTES. Beat k carries bytes base+k*BUS_BYTES .. base+k*BUS_BYTES+BUS_BYTES-1.
- Reset (async assert, sync release):
  - state = IDLE.
  - cmd_ready = 1; rdata_valid = 0; done = 0; rdata = 0.
  - Counters cleared.
  - Storage contents are not reset.
- Handshake:
  - A request is accepted on a posedge with cmd_valid && cmd_ready.
  - Address and op are latched at acceptance.
  - cmd_ready = 1 only in IDLE; requests while busy are ignored and must be held by the master.
- IDLE:
  - Accept read -> RWAIT, lat_cnt = LATENCY.
  - Accept write -> WCOLLECT, beat_cnt = 0.
- WCOLLECT:
  - Each cycle with wdata_valid, latch wdata into line buffer beat[beat_cnt] and increment beat_cnt.
  - wdata_valid low stalls; no timeout.
  - After beat BEATS-1 is latched -> WWAIT, lat_cnt = LATENCY.
  - wdata_valid in the acceptance cycle itself is not sampled.
- WWAIT:
  - Decrement lat_cnt each cycle.
  - At lat_cnt == 1, write the whole buffer to storage atomically, pulse done next cycle -> IDLE.
- RWAIT:
  - Decrement lat_cnt.
  - At lat_cnt == 1 -> RBURST, beat_cnt = 0.
- RBURST:
  - rdata_valid = 1 for BEATS consecutive cycles, no backpressure.
  - rdata = beat[beat_cnt] read from storage.
  - done = 1 in the same cycle as the last beat, then -> IDLE (cmd_ready = 1 the next cycle).
- Latency:
  - Read: first beat LATENCY+1 cycles after the acceptance edge; BEATS beats total.
  - Write: done LATENCY+1 cycles after the edge latching the last beat.
- Ordering: a write's commit precedes its done, so a read accepted after done returns the new data.
- Addressing: line-aligned; the top line (all-ones upper bits) is valid; no wrap within a line.
- Reset mid-operation:
  - Any in-flight request is aborted.
  - A partially collected or uncommitted write leaves storage untouched.
  - Committed lines persist.
- Counter widths: lat_cnt $clog2(LATENCY+1); beat_cnt $clog2(BEATS)+1.
- Illegal cmd_write/cmd_addr changes while not in IDLE have no effect.

Test Plan:
1. Defaults, write line 0x00100 with bytes 0x00..0x0F (8 beats, wdata_valid continuous) -> done exactly 101 cycles after 8th beat edge; cmd_ready low throughout; then read 0x00100 -> first beat 0x0100 at acceptance+101, beats 0x0302..0x0F0E, done with 8th beat.
2. Read 0x0010F (unaligned) -> identical data to read of 0x00100.
3. Write with wdata_valid gaps (beats on cycles 1,4,5,9,...) -> beats stored in order, no skipped or duplicated bytes on readback.
4. cmd_valid held high during a read burst with a second request -> second accepted only the cycle after done; not before.
5. Assert rst_n low during WWAIT of write to 0x7FFF0 over prior data 0xAA.. -> outputs at reset values immediately; readback returns 0xAA.. (write discarded).
6. Override LINE_BYTES=32, BUS_BYTES=4, LATENCY=1 -> 8 beats of 32-bit data, read first beat 2 cycles after acceptance, done on beat 8.
